// File: rtl/exp_time_logger_if.sv
// exp_time_logger_if: control inputs and result registers of the
// reaction-time logger, with driver (master) and logger (slave) views.
interface exp_time_logger_if;
  logic       start;
  logic       tick;
  logic       trig;
  logic [3:0] ET0;
  logic [3:0] ET1;
  logic [3:0] ET2;
  logic [3:0] ET3;
  logic [3:0] ET4;
  logic [3:0] ET5;
  logic [3:0] ET6;
  logic [3:0] ET7;
  logic [3:0] ET8;
  logic [3:0] ET9;
  logic [3:0] ET10;
  logic [3:0] cur_exp;
  logic [7:0] sum_val;
  logic       busy;
  logic       done;

  modport master (
    output start, tick, trig,
    input  ET0, ET1, ET2, ET3, ET4, ET5,
    input  ET6, ET7, ET8, ET9, ET10,
    input  cur_exp, sum_val, busy, done
  );

  modport slave (
    input  start, tick, trig,
    output ET0, ET1, ET2, ET3, ET4, ET5,
    output ET6, ET7, ET8, ET9, ET10,
    output cur_exp, sum_val, busy, done
  );
endinterface

// File: rtl/exp_time_logger.sv
// exp_time_logger: sequences 11 timed experiments into saturating BCD slots.
// Optional `TRIG_SYNC_EN adds a 2-flop synchronizer on trig.
module exp_time_logger #(
  parameter int NUM_EXP   = 11,
  parameter int MAX_DIGIT = 9
) (
  input  logic               clk,
  input  logic               rst,
  exp_time_logger_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE, RUN, STORE, DONE
  } state_e;

  localparam logic [3:0] LAST = 4'(NUM_EXP - 1);
  localparam logic [3:0] MAXD = 4'(MAX_DIGIT);

  state_e     state_q, state_d;
  logic [3:0] et_q [NUM_EXP];
  logic [3:0] et_d [NUM_EXP];
  logic [3:0] elap_q, elap_d;
  logic [3:0] cur_q, cur_d;
  logic [7:0] sum_q, sum_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       trig_s, trig_q;
  logic       trig_edge;

`ifdef TRIG_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.trig;
      sync2_q <= sync1_q;
    end
  end

  assign trig_s = sync2_q;
`else
  assign trig_s = bus.trig;
`endif

  assign trig_edge = trig_s & ~trig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // start overrides everything, including a pending STORE
  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      bus.start:
        state_d = RUN;
      state_q == RUN && trig_edge:
        state_d = STORE;
      state_q == STORE && cur_q == LAST:
        state_d = DONE;
      state_q == STORE:
        state_d = RUN;
      default: ;
    endcase
  end

  always_comb begin
    busy_d = (state_d == RUN) || (state_d == STORE);
    done_d = (state_d == DONE);
    et_d   = et_q;
    elap_d = elap_q;
    cur_d  = cur_q;
    sum_d  = sum_q;
    if (bus.start) begin
      for (int i = 0; i < NUM_EXP; i++) et_d[i] = 4'd0;
      elap_d = 4'd0;
      cur_d  = 4'd0;
      sum_d  = 8'd0;
    end else if (state_q == RUN) begin
      if (bus.tick && !trig_edge && elap_q != MAXD)
        elap_d = elap_q + 4'd1;
    end else if (state_q == STORE) begin
      et_d[cur_q] = elap_q;
      sum_d       = sum_q + {4'd0, elap_q};
      if (cur_q != LAST) begin
        cur_d  = cur_q + 4'd1;
        elap_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_EXP; i++) et_q[i] <= 4'd0;
      elap_q <= 4'd0;
      cur_q  <= 4'd0;
      sum_q  <= 8'd0;
      trig_q <= 1'b0;
    end else begin
      et_q   <= et_d;
      elap_q <= elap_d;
      cur_q  <= cur_d;
      sum_q  <= sum_d;
      trig_q <= trig_s;
    end
  end

  assign bus.ET0     = et_q[0];
  assign bus.ET1     = et_q[1];
  assign bus.ET2     = et_q[2];
  assign bus.ET3     = et_q[3];
  assign bus.ET4     = et_q[4];
  assign bus.ET5     = et_q[5];
  assign bus.ET6     = et_q[6];
  assign bus.ET7     = et_q[7];
  assign bus.ET8     = et_q[8];
  assign bus.ET9     = et_q[9];
  assign bus.ET10    = et_q[10];
  assign bus.cur_exp = cur_q;
  assign bus.sum_val = sum_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_exp_time_logger.sv
// tb_exp_time_logger: scoreboard bench for exp_time_logger.
// Expected slot/sum/index pushed on each trig, popped once stored.
module tb_exp_time_logger;
`ifdef TRIG_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int WR = SYNC + 2;

  typedef struct {
    int idx;
    int et;
    int sum;
    int cur;
    bit done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exp_time_logger_if bus ();

  exp_time_logger dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_et[11];
  int   m_sum;
  int   m_cur;
  bit   m_done;

  function automatic int get_et(int i);
    case (i)
      0: return int'(bus.ET0);
      1: return int'(bus.ET1);
      2: return int'(bus.ET2);
      3: return int'(bus.ET3);
      4: return int'(bus.ET4);
      5: return int'(bus.ET5);
      6: return int'(bus.ET6);
      7: return int'(bus.ET7);
      8: return int'(bus.ET8);
      9: return int'(bus.ET9);
      10: return int'(bus.ET10);
      default: return -1;
    endcase
  endfunction

  function automatic int et_nonzero();
    int n = 0;
    for (int i = 0; i < 11; i++)
      if (get_et(i) != 0) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 11; i++) m_et[i] = 0;
    m_sum  = 0;
    m_cur  = 0;
    m_done = 1'b0;
    sb.delete();
  endtask

  task automatic push_exp(int v);
    exp_t e;
    m_et[m_cur] = v;
    m_sum += v;
    e.idx = m_cur;
    e.et  = v;
    if (m_cur == 10) m_done = 1'b1;
    else m_cur++;
    e.sum  = m_sum;
    e.cur  = m_cur;
    e.done = m_done;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    model_clear();
  endtask

  task automatic run_exp(int n, bit coinc, int hold);
    int tot;
    for (int k = 0; k < SYNC + 1; k++) step();
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
    end
    push_exp(n > 9 ? 9 : n);
    bus.trig = 1'b1;
    tot = hold > WR ? hold : WR;
    for (int j = 0; j < tot; j++) begin
      if (coinc && j == SYNC) bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      if (j + 1 >= hold) bus.trig = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++;
    if (et_nonzero() != 0 || bus.cur_exp !== 4'd0 || bus.sum_val !== 8'd0) begin
      bad++;
      $display("FAIL reset_regs et_nz=%0d cur=%0d sum=%0d want 0", et_nonzero(), bus.cur_exp, bus.sum_val);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_run();
    exp_t e;
    pulse_start();
    for (int x = 0; x < 11; x++) begin
      run_exp(3, 1'b0, 1);
      e = sb.pop_front();
      total++;
      if (get_et(e.idx) != e.et) begin
        bad++;
        $display("FAIL full_et%0d got=%0d want=%0d", e.idx, get_et(e.idx), e.et);
      end
      total++;
      if (int'(bus.sum_val) != e.sum || int'(bus.cur_exp) != e.cur) begin
        bad++;
        $display("FAIL full_sum_cur%0d got=%0d/%0d want=%0d/%0d", e.idx, bus.sum_val, bus.cur_exp, e.sum, e.cur);
      end
      total++;
      if (bus.done !== e.done) begin
        bad++;
        $display("FAIL full_done%0d got=%b want=%b", e.idx, bus.done, e.done);
      end
    end
    for (int r = 0; r < 3; r++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      bus.trig = 1'b1;
      step();
      bus.trig = 1'b0;
      step();
    end
    total++;
    if (bus.sum_val !== 8'd33 || bus.cur_exp !== 4'd10 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL done_hold sum=%0d cur=%0d done=%b busy=%b want 33 10 1 0", bus.sum_val, bus.cur_exp, bus.done, bus.busy);
    end
    for (int i = 0; i < 11; i++) begin
      total++;
      if (get_et(i) != 3) begin
        bad++;
        $display("FAIL done_et%0d got=%0d want=3", i, get_et(i));
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    pulse_start();
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || et_nonzero() != 0 || bus.sum_val !== 8'd0 || bus.cur_exp !== 4'd0) begin
      bad++;
      $display("FAIL start_clear busy=%b done=%b et_nz=%0d sum=%0d cur=%0d want 1 0 0 0 0", bus.busy, bus.done, et_nonzero(), bus.sum_val, bus.cur_exp);
    end
    run_exp(15, 1'b0, 1);
    e = sb.pop_front();
    total++;
    if (get_et(e.idx) != e.et || int'(bus.sum_val) != e.sum || int'(bus.cur_exp) != e.cur) begin
      bad++;
      $display("FAIL saturate et=%0d sum=%0d cur=%0d want %0d %0d %0d", get_et(e.idx), bus.sum_val, bus.cur_exp, e.et, e.sum, e.cur);
    end
  endtask

  task automatic test_tick_trig();
    exp_t e;
    run_exp(2, 1'b1, 20);
    e = sb.pop_front();
    total++;
    if (get_et(e.idx) != e.et) begin
      bad++;
      $display("FAIL tick_drop et%0d got=%0d want=%0d", e.idx, get_et(e.idx), e.et);
    end
    total++;
    if (int'(bus.sum_val) != e.sum || int'(bus.cur_exp) != e.cur) begin
      bad++;
      $display("FAIL trig_hold sum=%0d cur=%0d want %0d %0d", bus.sum_val, bus.cur_exp, e.sum, e.cur);
    end
  endtask

  task automatic test_restart();
    exp_t e;
    run_exp(4, 1'b0, 1);
    run_exp(6, 1'b0, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (get_et(e.idx) != e.et || int'(bus.cur_exp) != 4) begin
        bad++;
        $display("FAIL pre_restart et%0d got=%0d want=%0d cur=%0d", e.idx, get_et(e.idx), e.et, bus.cur_exp);
      end
    end
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    pulse_start();
    total++;
    if (et_nonzero() != 0 || bus.sum_val !== 8'd0 || bus.cur_exp !== 4'd0) begin
      bad++;
      $display("FAIL restart_clear et_nz=%0d sum=%0d cur=%0d want 0", et_nonzero(), bus.sum_val, bus.cur_exp);
    end
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL restart_state busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    run_exp(2, 1'b0, 1);
    e = sb.pop_front();
    total++;
    if (get_et(e.idx) != e.et || int'(bus.cur_exp) != e.cur) begin
      bad++;
      $display("FAIL restart_elapsed et=%0d cur=%0d want %0d %0d", get_et(e.idx), bus.cur_exp, e.et, e.cur);
    end
  endtask

  task automatic test_latency();
    exp_t e;
    int   pre_cur;
    for (int k = 0; k < SYNC + 1; k++) step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    pre_cur = m_cur;
    push_exp(1);
    bus.trig = 1'b1;
    for (int j = 1; j <= WR; j++) begin
      step();
      bus.trig = 1'b0;
      if (j < WR) begin
        total++;
        if (int'(bus.cur_exp) != pre_cur) begin
          bad++;
          $display("FAIL latency_early step=%0d cur=%0d want=%0d", j, bus.cur_exp, pre_cur);
        end
      end
    end
    e = sb.pop_front();
    total++;
    if (int'(bus.cur_exp) != e.cur || get_et(e.idx) != e.et || int'(bus.sum_val) != e.sum) begin
      bad++;
      $display("FAIL latency_write cur=%0d et=%0d sum=%0d want %0d %0d %0d", bus.cur_exp, get_et(e.idx), bus.sum_val, e.cur, e.et, e.sum);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    pulse_start();
    run_exp(1, 1'b0, 1);
    run_exp(1, 1'b0, 1);
    run_exp(1, 1'b0, 1);
    run_exp(5, 1'b0, 1);
    e = sb[$];
    total++;
    if (get_et(3) != e.et || int'(bus.sum_val) != e.sum) begin
      bad++;
      $display("FAIL pre_reset et3=%0d sum=%0d want %0d %0d", get_et(3), bus.sum_val, e.et, e.sum);
    end
    sb.delete();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (et_nonzero() != 0 || bus.cur_exp !== 4'd0 || bus.sum_val !== 8'd0) begin
      bad++;
      $display("FAIL async_reset et_nz=%0d cur=%0d sum=%0d want 0", et_nonzero(), bus.cur_exp, bus.sum_val);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_flags busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    step();
    rst = 1'b0;
    model_clear();
    step();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    bus.trig  = 1'b0;
    model_clear();
    test_reset();
    test_full_run();
    test_saturate();
    test_tick_trig();
    test_restart();
    test_latency();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
